// File: rtl/updown_counter_7seg.sv
// Up/down counter with edge-detected buttons, parallel load, wrap/saturate limits,
// and a sequential double-dabble converter driving N-digit active-low 7-segment output.
module updown_counter_7seg #(
    parameter int             N        = 6,
    parameter int             DIGITS   = 2,
    parameter bit             SATURATE = 1'b0,
    parameter logic [N-1:0]   INIT     = {N{1'b1}}
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  inc,
    input  logic                  dec,
    input  logic                  load,
    input  logic [N-1:0]          load_value,
    output logic [N-1:0]          count,
    output logic                  zero,
    output logic                  limit,
    output logic [7*DIGITS-1:0]   seg,
    output logic                  disp_valid
);

    localparam int             BW       = 4 * DIGITS;
    localparam int             CW       = $clog2(N + 1);
    localparam logic [N-1:0]   MAX      = {N{1'b1}};
    localparam logic [N-1:0]   ONE      = {{(N-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]  CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]  LAST_BIT = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        WRITE = 2'd2
    } conv_state_t;

    // ------------------------------------------------------------------
    // Counter
    // ------------------------------------------------------------------
    logic         inc_prev, dec_prev;
    logic         inc_ev, dec_ev;
    logic [N-1:0] count_next;
    logic         limit_next;

    assign inc_ev = inc & ~inc_prev;
    assign dec_ev = dec & ~dec_prev;
    assign zero   = (count == '0);

    always_comb begin
        count_next = count;
        limit_next = 1'b0;
        if (load) begin
            count_next = load_value;
        end else if (inc_ev && dec_ev) begin
            count_next = count;
        end else if (inc_ev) begin
            if (count == MAX) begin
                limit_next = 1'b1;
                count_next = SATURATE ? MAX : '0;
            end else begin
                count_next = count + ONE;
            end
        end else if (dec_ev) begin
            if (count == '0) begin
                limit_next = 1'b1;
                count_next = SATURATE ? '0 : MAX;
            end else begin
                count_next = count - ONE;
            end
        end
    end

    // Prev registers sample the buttons even in reset so a held button is not an edge.
    always_ff @(posedge clk) begin
        inc_prev <= inc;
        dec_prev <= dec;
        if (reset) begin
            count <= INIT;
            limit <= 1'b0;
        end else begin
            count <= count_next;
            limit <= limit_next;
        end
    end

    // ------------------------------------------------------------------
    // Binary to BCD converter and segment encoder
    // ------------------------------------------------------------------
    function automatic logic [BW-1:0] dabble_adjust(input logic [BW-1:0] b);
        logic [BW-1:0] r;
        r = b;
        for (int k = 0; k < DIGITS; k++) begin
            if (b[4*k +: 4] >= 4'd5) begin
                r[4*k +: 4] = b[4*k +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    conv_state_t           state, state_next;
    logic [N-1:0]          snap, snap_next;
    logic [N-1:0]          sr, sr_next;
    logic [N-1:0]          shown, shown_next;
    logic [BW-1:0]         bcd, bcd_next;
    logic [CW-1:0]         bit_cnt, bit_cnt_next;
    logic                  first, first_next;
    logic [7*DIGITS-1:0]   seg_next;
    logic                  disp_valid_next;

    always_comb begin
        state_next      = state;
        snap_next       = snap;
        sr_next         = sr;
        shown_next      = shown;
        bcd_next        = bcd;
        bit_cnt_next    = bit_cnt;
        first_next      = first;
        seg_next        = seg;
        disp_valid_next = disp_valid;
        case (state)
            IDLE: begin
                if (count != shown || first) begin
                    snap_next       = count;
                    sr_next         = count;
                    bcd_next        = '0;
                    bit_cnt_next    = '0;
                    disp_valid_next = 1'b0;
                    first_next      = 1'b0;
                    state_next      = SHIFT;
                end
            end
            SHIFT: begin
                {bcd_next, sr_next} = {dabble_adjust(bcd), sr} << 1;
                bit_cnt_next        = bit_cnt + CNT_ONE;
                if (bit_cnt == LAST_BIT) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                for (int k = 0; k < DIGITS; k++) begin
                    seg_next[7*k +: 7] = seg7(bcd[4*k +: 4]);
                end
                shown_next = snap;
                if (count == snap) begin
                    disp_valid_next = 1'b1;
                    state_next      = IDLE;
                end else begin
                    // Stale result: restart from the latest count in the same cycle,
                    // which keeps worst-case settling at two conversions.
                    snap_next       = count;
                    sr_next         = count;
                    bcd_next        = '0;
                    bit_cnt_next    = '0;
                    disp_valid_next = 1'b0;
                    state_next      = SHIFT;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            snap       <= '0;
            sr         <= '0;
            shown      <= '0;
            bcd        <= '0;
            bit_cnt    <= '0;
            first      <= 1'b1;
            seg        <= '1;
            disp_valid <= 1'b0;
        end else begin
            state      <= state_next;
            snap       <= snap_next;
            sr         <= sr_next;
            shown      <= shown_next;
            bcd        <= bcd_next;
            bit_cnt    <= bit_cnt_next;
            first      <= first_next;
            seg        <= seg_next;
            disp_valid <= disp_valid_next;
        end
    end

endmodule

// File: tb/tb_updown_counter_7seg.sv
// Bench for updown_counter_7seg: directed button/load sequences, with a display scoreboard
// that checks each newly valid 7-segment image against the expected count.
module tb_updown_counter_7seg;

    localparam int N      = 6;
    localparam int DIGITS = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         inc, dec, load;
    logic [N-1:0] load_value;

    logic [N-1:0]          count, count_s;
    logic                  zero, zero_s, limit, limit_s;
    logic [7*DIGITS-1:0]   seg, seg_s;
    logic                  disp_valid, disp_valid_s;

    updown_counter_7seg #(.N(N), .DIGITS(DIGITS), .SATURATE(1'b0)) dut (
        .clk(clk), .reset(reset), .inc(inc), .dec(dec), .load(load),
        .load_value(load_value), .count(count), .zero(zero), .limit(limit),
        .seg(seg), .disp_valid(disp_valid)
    );

    updown_counter_7seg #(.N(N), .DIGITS(DIGITS), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .reset(reset), .inc(inc), .dec(dec), .load(load),
        .load_value(load_value), .count(count_s), .zero(zero_s), .limit(limit_s),
        .seg(seg_s), .disp_valid(disp_valid_s)
    );

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [N-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] digit_pat(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [13:0] seg_model(input int v);
        return {digit_pat(v / 10), digit_pat(v % 10)};
    endfunction

    // Monitor: every rising edge of disp_valid presents a new display image.
    initial begin
        logic         prev_valid;
        logic [N-1:0] v;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (disp_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    check("mon_unexpected_display", 32'(count), 32'hffff_ffff);
                end else begin
                    v = exp_q.pop_front();
                    check("mon_seg", 32'(seg), 32'(seg_model(int'(v))));
                    check("mon_count", 32'(count), 32'(v));
                end
            end
            prev_valid = disp_valid;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_dec();
        dec = 1'b1;
        step(1);
        dec = 1'b0;
    endtask

    task automatic do_load(input logic [N-1:0] v);
        load       = 1'b1;
        load_value = v;
        step(1);
        load = 1'b0;
    endtask

    task automatic wait_valid(input int budget, input string name);
        int i;
        i = 0;
        while (!disp_valid && i < budget) begin
            step(1);
            i++;
        end
        check(name, 32'(disp_valid), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic saw_valid;
        reset = 1'b1; inc = 1'b0; dec = 1'b0; load = 1'b0; load_value = '0;
        step(2);
        check("rst_count", 32'(count), 32'd63);
        check("rst_seg_blank", 32'(seg), 32'h3fff);
        check("rst_disp_valid", 32'(disp_valid), 32'd0);
        check("rst_limit", 32'(limit), 32'd0);
        check("rst_sat_count", 32'(count_s), 32'd63);

        // 1: release reset, first conversion of INIT
        reset = 1'b0;
        exp_q.push_back(6'd63);
        wait_valid(8, "t1_disp_latency");
        check("t1_zero", 32'(zero), 32'd0);
        check("t1_seg_63", 32'(seg), 32'({7'b0000010, 7'b0110000}));

        // 2: count down to zero, then hit the lower limit
        for (int i = 1; i <= 63; i++) begin
            exp_q.push_back(6'(63 - i));
            pulse_dec();
            check("t2_count", 32'(count), 32'(63 - i));
            check("t2_sat_count", 32'(count_s), 32'(63 - i));
            step(9);
        end
        check("t2_zero", 32'(zero), 32'd1);
        check("t2_seg_00", 32'(seg), 32'({7'b1000000, 7'b1000000}));
        exp_q.push_back(6'd63);
        pulse_dec();
        check("t2_wrap_count", 32'(count), 32'd63);
        check("t2_wrap_limit", 32'(limit), 32'd1);
        check("t2_sat_count_hold", 32'(count_s), 32'd0);
        check("t2_sat_limit", 32'(limit_s), 32'd1);
        check("t2_sat_zero", 32'(zero_s), 32'd1);
        step(1);
        check("t2_limit_one_cycle", 32'(limit), 32'd0);
        check("t2_sat_limit_one_cycle", 32'(limit_s), 32'd0);
        step(9);

        // 3: held button counts once; simultaneous edges cancel
        exp_q.push_back(6'd30);
        do_load(6'd30);
        check("t3_load_count", 32'(count), 32'd30);
        check("t3_sat_load_count", 32'(count_s), 32'd30);
        step(10);
        exp_q.push_back(6'd29);
        dec = 1'b1;
        step(20);
        dec = 1'b0;
        check("t3_hold_once", 32'(count), 32'd29);
        step(2);
        inc = 1'b1; dec = 1'b1;
        step(1);
        check("t3_both_count", 32'(count), 32'd29);
        check("t3_both_limit", 32'(limit), 32'd0);
        inc = 1'b0; dec = 1'b0;
        step(10);

        // 4: load wins over a concurrent increment edge
        exp_q.push_back(6'd42);
        inc = 1'b1;
        do_load(6'd42);
        inc = 1'b0;
        check("t4_load_count", 32'(count), 32'd42);
        check("t4_load_limit", 32'(limit), 32'd0);
        step(10);
        check("t4_seg_42", 32'(seg), 32'({7'b0011001, 7'b0100100}));
        check("t4_disp_valid", 32'(disp_valid), 32'd1);

        // 5: burst faster than the converter
        exp_q.push_back(6'd63);
        do_load(6'd63);
        step(10);
        exp_q.push_back(6'd53);
        saw_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            pulse_dec();
            step(1);
            if (disp_valid) saw_valid = 1'b1;
        end
        check("t5_invalid_during_burst", 32'(saw_valid), 32'd0);
        check("t5_count", 32'(count), 32'd53);
        wait_valid(16, "t5_settle_latency");
        check("t5_seg_53", 32'(seg), 32'({7'b0010010, 7'b0110000}));
        step(4);

        // 6: reset during SHIFT, then reset with inc held
        do_load(6'd20);
        step(3);
        reset = 1'b1;
        step(1);
        check("t6_rst_seg_blank", 32'(seg), 32'h3fff);
        check("t6_rst_disp_valid", 32'(disp_valid), 32'd0);
        check("t6_rst_count", 32'(count), 32'd63);
        inc = 1'b1;
        step(1);
        reset = 1'b0;
        exp_q.push_back(6'd63);
        step(3);
        check("t6_held_inc_count", 32'(count), 32'd63);
        check("t6_held_inc_limit", 32'(limit), 32'd0);
        check("t6_sat_held_inc_count", 32'(count_s), 32'd63);
        inc = 1'b0;
        step(10);
        check("t6_seg_63", 32'(seg), 32'({7'b0000010, 7'b0110000}));

        step(5);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
